uart_rx_shifter: RTL and testbench
==================================

UART_RX_SHIFTER -- requirements
Module: uart_rx_shifter

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame, LSB first.
REQ-003 clk  input  1  single system clock; all flops rise-edge triggered.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 rx_pin  input  1  raw asynchronous UART line; idles high.
REQ-006 stop_valid  input  1  from the stop-bit checker; stop bit good, qualified by shift_done.
REQ-007 fram_err  input  1  from the stop-bit checker; stop bit bad, qualified by shift_done.
REQ-008 serial_sync  output  1  synchronized rx_pin; drives the checker's serial_in.
REQ-009 shift_done  output  1  one-cycle pulse at the stop-bit mid-sample; drives the checker's shift_done.
REQ-010 rx_data  output  DATA_BITS  last accepted byte.
REQ-011 rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-012 rx_frame_err  output  1  one-cycle pulse: frame rejected for a bad stop bit.
REQ-013 rx_busy  output  1  high in any state other than IDLE.

Function
REQ-014 rx_pin SHALL pass through a 2-flop synchronizer; serial_sync is the second flop output, giving 2-cycle latency.
REQ-015 The FSM SHALL have the states IDLE, START, DATA and STOP; transitions are evaluated on each clk edge.
REQ-016 IDLE->START SHALL occur on a serial_sync falling edge (prev=1, cur=0), with the bit counter cleared.
  - The FSM SHALL accept no start until serial_sync has been seen high at least once after reset or after a frame.
REQ-017 In START, when the bit counter reaches CLKS_PER_BIT/2-1 (integer divide), serial_sync SHALL be sampled:
  - If serial_sync=0, the FSM SHALL go to DATA with the counter and bit index cleared.
  - If serial_sync=1, the FSM SHALL go to IDLE as a glitch, with no output pulse.
REQ-018 In DATA, each time the counter reaches CLKS_PER_BIT-1, serial_sync SHALL be shifted into the MSB of the shift register (right shift, LSB first), the counter cleared and the bit index incremented.
  - After DATA_BITS samples, the FSM SHALL go to STOP.
REQ-019 In STOP, when the counter reaches CLKS_PER_BIT-1, shift_done SHALL be 1 for exactly that cycle, and the FSM SHALL go to IDLE on the next edge.
REQ-020 In the shift_done cycle, the block SHALL register the checker response:
  - If stop_valid=1, rx_data SHALL load the shift register and rx_valid SHALL pulse on the next cycle.
  - If fram_err=1, rx_frame_err SHALL pulse on the next cycle and rx_data SHALL hold.
  - stop_valid=1 and fram_err=1 together is illegal; in that case stop_valid SHALL take priority.
REQ-021 stop_valid and fram_err SHALL be ignored when shift_done=0.
REQ-022 The bit counter width SHALL be $clog2(CLKS_PER_BIT); the counter never wraps, because it is cleared at each terminal count.
REQ-023 The bit-index width SHALL be $clog2(DATA_BITS+1).
REQ-024 A line low through the whole frame (break) SHALL yield one shift_done, then IDLE waits for line high per REQ-016.
REQ-025 The block SHALL hold no combinational path from rx_pin, stop_valid or fram_err to any output.

Reset
REQ-026 On rst=1 the block SHALL asynchronously take these values:
  - FSM=IDLE; counter, bit index and shift register=0.
  - synchronizer flops and the previous-sample flop=1, so no false start is seen.
  - rx_data=0; shift_done, rx_valid, rx_frame_err, rx_busy=0.
REQ-027 rst asserted mid-frame SHALL abort the frame with no rx_valid or rx_frame_err pulse; after release, the block SHALL wait for a fresh falling edge.

Structure
REQ-028 The FSM state encoding (2-bit enum) SHALL live in the shared package uart_pkg, together with the default CLKS_PER_BIT and DATA_BITS constants.
REQ-029 The synchronizer SHALL be a separate sub-module, sync_2ff, with ports clk, rst, d, q and reset value 1.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, checker instantiated)
REQ-030 Frame 0x55 with a good stop bit -> one shift_done, rx_valid one cycle later, rx_data=0x55, rx_frame_err=0.
REQ-031 Frame 0xA3 with the stop bit driven 0 -> shift_done, rx_frame_err pulse, rx_data keeps the prior 0x55, rx_valid=0.
REQ-032 A 4-cycle low glitch on idle rx_pin -> return to IDLE at the START mid-sample, no shift_done, rx_busy low again.
REQ-033 rst pulsed at data bit 4 of frame 0xFF -> all outputs 0; the next clean frame 0x0F yields rx_data=0x0F.
REQ-034 Back-to-back frames 0x01 and 0x80 with a 1-bit stop and no idle gap -> two rx_valid pulses, rx_data 0x01 then 0x80.
REQ-035 Line held low for 20 bit times, then high -> exactly one shift_done and one rx_frame_err; no further frame until a new falling edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding and default frame timing.
package uart_pkg;

  // 100 MHz system clock, 115200 baud
  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 1 (idle UART line).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  // Double-register the asynchronous input to settle metastability
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b1;
      q_reg    <= 1'b1;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/uart_rx_shifter.sv
// UART receive shifter: start detection, mid-bit sampling of LSB-first data,
// and a stop-bit sample strobe handed to an external stop-bit checker whose
// verdict decides whether the byte is accepted or flagged as a framing error.
module uart_rx_shifter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  input  logic                 stop_valid,
  input  logic                 fram_err,
  output logic                 serial_sync,
  output logic                 shift_done,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  rx_state_t              state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   armed_reg, armed_next;
  logic                   prev_reg;
  logic                   done_w;
  logic [DATA_BITS-1:0]   rx_data_reg;
  logic                   rx_valid_reg;
  logic                   rx_frame_err_reg;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_pin),
    .q   (serial_sync)
  );

  // Next-state logic. armed_reg blocks a new start until the line has been
  // seen idle-high, so a held-low line (break) cannot retrigger frames.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    armed_next = armed_reg;
    done_w     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (serial_sync) begin
          armed_next = 1'b1;
        end
        if (armed_reg && prev_reg && !serial_sync) begin
          state_next = ST_START;
          cnt_next   = '0;
        end
      end
      ST_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (!serial_sync) begin
            state_next = ST_DATA;
            idx_next   = '0;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {serial_sync, shift_reg[DATA_BITS-1:1]};
          idx_next   = idx_reg + IDX_W'(1);
          if (idx_reg == IDX_LAST) begin
            state_next = ST_STOP;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          done_w     = 1'b1;
          cnt_next   = '0;
          state_next = ST_IDLE;
          armed_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters, shift register and previous-sample register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      armed_reg <= 1'b0;
      prev_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      armed_reg <= armed_next;
      prev_reg  <= serial_sync;
    end
  end

  // Register the checker verdict taken in the stop-sample cycle; valid wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rx_frame_err_reg <= 1'b0;
    end else begin
      rx_valid_reg     <= 1'b0;
      rx_frame_err_reg <= 1'b0;
      if (done_w) begin
        if (stop_valid) begin
          rx_data_reg  <= shift_reg;
          rx_valid_reg <= 1'b1;
        end else if (fram_err) begin
          rx_frame_err_reg <= 1'b1;
        end
      end
    end
  end

  assign shift_done   = done_w;
  assign rx_data      = rx_data_reg;
  assign rx_valid     = rx_valid_reg;
  assign rx_frame_err = rx_frame_err_reg;
  assign rx_busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_shifter.sv
// Self-checking bench for uart_rx_shifter with a simple stop-bit checker.
// Expected results come from a frame-level model: each frame sent yields one
// stop sample; a high stop bit delivers the byte, a low one flags an error.
module tb_uart_rx_shifter;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_pin;
  logic          stop_valid;
  logic          fram_err;
  logic          serial_sync;
  logic          shift_done;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_frame_err;
  logic          rx_busy;

  int n_cmp = 0;
  int n_bad = 0;

  int sd_cnt = 0;
  int v_cnt  = 0;
  int fe_cnt = 0;
  logic sd_prev = 1'b0;
  logic [DB-1:0] vq[$];
  logic [DB-1:0] model_data;

  always #5 clk = ~clk;

  // Stop-bit checker: judges the synchronized line; only meaningful when
  // qualified by shift_done, so the DUT must ignore it otherwise.
  assign stop_valid = serial_sync;
  assign fram_err   = ~serial_sync;

  uart_rx_shifter #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_pin       (rx_pin),
    .stop_valid   (stop_valid),
    .fram_err     (fram_err),
    .serial_sync  (serial_sync),
    .shift_done   (shift_done),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor: counts strobes and checks result pulses trail shift_done
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        check("valid_after_done", {31'd0, sd_prev}, 32'd1);
        vq.push_back(rx_data);
        v_cnt++;
      end
      if (rx_frame_err) begin
        check("ferr_after_done", {31'd0, sd_prev}, 32'd1);
        fe_cnt++;
      end
      if (shift_done) sd_cnt++;
    end
    sd_prev = shift_done;
  end

  task automatic wait_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input int gap_bits);
    rx_pin = 1'b0;
    wait_bits(1);
    for (int i = 0; i < DB; i++) begin
      rx_pin = d[i];
      wait_bits(1);
    end
    rx_pin = stop_bit;
    wait_bits(1);
    rx_pin = 1'b1;
    wait_bits(gap_bits);
  endtask

  task automatic pop_check(input string tag, input logic [DB-1:0] exp);
    logic [DB-1:0] got;
    got = '1;
    if (vq.size() > 0) got = vq.pop_front();
    else check({tag, "_missing"}, 32'd0, 32'd1);
    check(tag, {24'd0, got}, {24'd0, exp});
  endtask

  // One complete frame followed by idle, checked against the frame model
  task automatic do_frame(input logic [DB-1:0] d, input logic stop_ok, input int gap_bits);
    int sd0, v0, fe0;
    sd0 = sd_cnt; v0 = v_cnt; fe0 = fe_cnt;
    send_frame(d, stop_ok, gap_bits);
    check("done_count", sd_cnt - sd0, 32'd1);
    check("valid_count", v_cnt - v0, stop_ok ? 32'd1 : 32'd0);
    check("ferr_count", fe_cnt - fe0, stop_ok ? 32'd0 : 32'd1);
    if (stop_ok) begin
      model_data = d;
      pop_check("valid_data", d);
    end
    check("rx_data", {24'd0, rx_data}, {24'd0, model_data});
    check("busy_idle", {31'd0, rx_busy}, 32'd0);
    $display("frame data=%02h stop=%0d -> rx_data=%02h exp=%02h", d, stop_ok, rx_data, model_data);
  endtask

  initial begin
    int sd0, v0, fe0;
    logic seen_busy;
    logic [DB-1:0] d;
    logic ok;

    // Reset with the line low: synchronizer must still read idle-high
    rst = 1'b1;
    rx_pin = 1'b0;
    model_data = '0;
    repeat (3) @(negedge clk);
    check("rst_serial_sync", {31'd0, serial_sync}, 32'd1);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_outputs", {28'd0, shift_done, rx_valid, rx_frame_err, rx_busy}, 32'd0);
    rx_pin = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_bits(2);
    $display("reset: serial_sync=%0d rx_data=%02h busy=%0d", serial_sync, rx_data, rx_busy);

    // Good frame then bad stop bit: data must hold on the error
    do_frame(8'h55, 1'b1, 2);
    do_frame(8'hA3, 1'b0, 2);

    // Short low glitch on an idle line
    sd0 = sd_cnt; seen_busy = 1'b0;
    rx_pin = 1'b0;
    repeat (4) @(negedge clk);
    rx_pin = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (rx_busy) seen_busy = 1'b1;
    end
    check("glitch_busy_seen", {31'd0, seen_busy}, 32'd1);
    check("glitch_no_done", sd_cnt - sd0, 32'd0);
    check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
    $display("glitch: done_delta=%0d busy_seen=%0d busy=%0d", sd_cnt - sd0, seen_busy, rx_busy);

    // Reset during data bit 4 of 0xFF
    sd0 = sd_cnt; v0 = v_cnt; fe0 = fe_cnt;
    rx_pin = 1'b0;
    wait_bits(1);
    rx_pin = 1'b1;
    wait_bits(4);
    rst = 1'b1;
    #1;
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    check("midrst_outputs", {28'd0, shift_done, rx_valid, rx_frame_err, rx_busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_data = '0;
    wait_bits(6);
    check("midrst_no_pulses", (sd_cnt - sd0) + (v_cnt - v0) + (fe_cnt - fe0), 32'd0);
    $display("midframe reset: rx_data=%02h busy=%0d", rx_data, rx_busy);
    do_frame(8'h0F, 1'b1, 2);

    // Back-to-back frames, no idle gap between them
    sd0 = sd_cnt; v0 = v_cnt;
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'h80, 1'b1, 2);
    check("b2b_done_count", sd_cnt - sd0, 32'd2);
    check("b2b_valid_count", v_cnt - v0, 32'd2);
    pop_check("b2b_first", 8'h01);
    pop_check("b2b_second", 8'h80);
    model_data = 8'h80;
    check("b2b_rx_data", {24'd0, rx_data}, {24'd0, model_data});
    $display("back-to-back: 01,80 -> rx_data=%02h", rx_data);

    // Break: line low for 20 bit times, then high with no new edge
    sd0 = sd_cnt; v0 = v_cnt; fe0 = fe_cnt;
    rx_pin = 1'b0;
    wait_bits(20);
    rx_pin = 1'b1;
    wait_bits(12);
    check("break_done_count", sd_cnt - sd0, 32'd1);
    check("break_ferr_count", fe_cnt - fe0, 32'd1);
    check("break_valid_count", v_cnt - v0, 32'd0);
    check("break_rx_data", {24'd0, rx_data}, {24'd0, model_data});
    check("break_busy_low", {31'd0, rx_busy}, 32'd0);
    $display("break: done_delta=%0d ferr_delta=%0d", sd_cnt - sd0, fe_cnt - fe0);

    // Randomized frames
    for (int k = 0; k < 30; k++) begin
      d  = DB'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      do_frame(d, ok, $urandom_range(1, 3));
    end

    check("queue_drained", vq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
